mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the multicycle core's unified instruction/data port.
//  Accepts one load/store request at a time and waits LATENCY cycles.
//  Returns lane-aligned, sign/zero-extended load data, or merges store data into a word array.
//  Sits between the core's Addr/WriteData/ReadData port and on-chip RAM.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words; power of two; AW = $clog2(DEPTH_WORDS)
//  LATENCY      2     cycles from request acceptance to rsp_valid; legal range 1..15
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  req_valid    in   1   request present
//  req_ready    out  1   responder idle; request accepted when req_valid & req_ready
//  req_we       in   1   1 = store, 0 = load
//  req_size     in   2   00 byte, 01 half, 10 word (11 treated as word)
//  req_unsigned in   1   load zero-extend (1) / sign-extend (0); ignored for word
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-justified (bits [7:0] for byte)
//  rsp_valid    out  1   one-cycle pulse: request complete
//  rsp_rdata    out  32  extended load data; held until next rsp_valid; 0 for stores
//  rsp_err      out  1   valid with rsp_valid; only driven 1 when MEM_ERR_EN defined
// BEHAVIOUR
//  Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, counter=0.
//  Memory contents are not reset.
//  FSM states:
//   IDLE: req_ready=1. On accept, latch we/size/unsigned/addr/wdata, counter=LATENCY-1.
//         LATENCY==1 goes straight to RESP; otherwise go to BUSY.
//   BUSY: req_ready=0. Counter decrements each cycle; at 0, go to RESP. req_valid ignored.
//   RESP: rsp_valid=1 for exactly one cycle, req_ready=0; next state IDLE.
//  The array access occurs in RESP.
//   Store: read-modify-write of word addr[AW+1:2]; only the addressed lanes change.
//   Load: read the word, shift the addressed lane to bit 0, extend per size/unsigned,
//         register into rsp_rdata.
//  Latency: request accepted at edge N -> rsp_valid high in cycle N+LATENCY.
//  Back-to-back: next accept is no earlier than one cycle after rsp_valid,
//   so throughput is one request per LATENCY+1 cycles.
//  Lane select: byte lane = addr[1:0]; half lane = addr[1]. Without MEM_ERR_EN,
//   sub-size address bits are ignored (half forces addr[0]=0, word forces addr[1:0]=0).
//  Out-of-range index: without MEM_ERR_EN, the address wraps modulo DEPTH_WORDS.
//  Store followed by load to the same word returns the new data (access is serialized).
//  rst high in any state: return to IDLE immediately; the pending store is NOT committed;
//   no rsp_valid is produced for the aborted request.
// CONFIGURATION
//  MEM_ERR_EN defined:
//   Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) sets rsp_err=1.
//   Address >= DEPTH_WORDS*4 also sets rsp_err=1.
//   On error: store suppressed, rsp_rdata=0; latency unchanged.
//  MEM_ERR_EN undefined: rsp_err tied 0; alignment forcing and wrap as above.
// STRUCTURE
//  Package mem_pkg:
//   size codes SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10;
//   FSM encoding S_IDLE, S_BUSY, S_RESP.
//  Sub-module mem_lane_align (combinational):
//   store direction: produces merged word + byte-enable;
//   load direction: produces shifted + extended data.
//  Word array inferred in mem_responder itself.
// TESTING
//  Reset: hold rst 2 cycles -> req_ready=1, rsp_valid=0, rsp_rdata=0.
//  Word store 0xDEADBEEF @0x10, then word load @0x10, LATENCY=2
//   -> rsp_valid exactly 2 cycles after each accept; load rsp_rdata=0xDEADBEEF.
//  Byte store 0xA5 @0x11 over word 0x00000000, then loads @0x11
//   -> signed byte 0xFFFFFFA5; unsigned byte 0x000000A5; word @0x10 = 0x0000A500.
//  Half load @0x12 of word 0x8001_1234 -> signed 0xFFFF8001; unsigned 0x00008001.
//  Store accepted, rst asserted in BUSY -> no rsp_valid; word unchanged on later load;
//   req_ready=1 the cycle after reset.
//  MEM_ERR_EN: word load @0x02 -> rsp_err=1, rsp_rdata=0.
//   Store @DEPTH_WORDS*4 -> rsp_err=1; word 0 unchanged.
//   Without the macro: load @0x02 reads word 0, rsp_err=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_RESP = 2'b10
    } state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Size code 2'b11 behaves as a full word.
    function automatic logic [1:0] norm_size(input logic [1:0] s);
        return (s == 2'b11) ? SZ_W : s;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering between a 32-bit word and sub-word accesses.
// Store side: replicated data merged under a byte-enable mask.
// Load side: addressed lane shifted to bit 0 and sign/zero extended.
// Sub-size address bits are dropped here (half ignores lane[0], word ignores both).
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [31:0] merged,
    output logic [3:0]  be,
    output logic [31:0] ldata
);

    logic [1:0]  sz;
    logic [1:0]  off;
    logic [31:0] repl;
    logic [31:0] shifted;

    assign sz = norm_size(size);

    // Aligned byte offset, byte enables and replicated store data per size.
    always_comb begin
        off  = 2'b00;
        be   = 4'hF;
        repl = wdata;
        case (sz)
            SZ_B: begin
                off  = lane;
                be   = 4'b0001 << lane;
                repl = {4{wdata[7:0]}};
            end
            SZ_H: begin
                off  = {lane[1], 1'b0};
                be   = 4'b0011 << {lane[1], 1'b0};
                repl = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            assign merged[i*LANE_W +: LANE_W] = be[i] ? repl[i*LANE_W +: LANE_W]
                                                      : word[i*LANE_W +: LANE_W];
        end
    endgenerate

    assign shifted = word >> {off, 3'b000};

    // Extend the shifted lane to 32 bits.
    always_comb begin
        ldata = word;
        case (sz)
            SZ_B:    ldata = {{24{~uns & shifted[7]}},  shifted[7:0]};
            SZ_H:    ldata = {{16{~uns & shifted[15]}}, shifted[15:0]};
            default: ldata = word;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder in front of an inferred word array.
// Request is latched on accept, held LATENCY cycles, then the array is
// accessed in RESP and the result registered with a one-cycle rsp_valid.
// Optional MEM_ERR_EN: flag misaligned or out-of-range accesses via rsp_err
// instead of forcing alignment and wrapping the index.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      state;
    logic [3:0]  cnt;
    req_t        req_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [31:0]   merged;
    logic [3:0]    be;
    logic [31:0]   ldata;
    logic          err;
    logic          commit;

    assign idx  = req_q.addr[AW+1:2];
    assign word = mem[idx];

    mem_lane_align u_align (
        .size   (req_q.size),
        .uns    (req_q.uns),
        .lane   (req_q.addr[1:0]),
        .wdata  (req_q.wdata),
        .word   (word),
        .merged (merged),
        .be     (be),
        .ldata  (ldata)
    );

`ifdef MEM_ERR_EN
    logic [1:0] sz_q;
    logic       misalign;
    logic       oor;
    assign sz_q     = norm_size(req_q.size);
    assign misalign = ((sz_q == SZ_H) & req_q.addr[0]) |
                      ((sz_q == SZ_W) & (|req_q.addr[1:0]));
    assign oor      = |req_q.addr[31:AW+2];
    assign err      = misalign | oor;
`else
    // Upper address bits only matter for range checking; here the index wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_q.addr[31:AW+2];
    assign err            = 1'b0;
`endif

    assign commit = (state == S_RESP) & req_q.we & ~err;

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_q     <= '{we: req_we, size: req_size, uns: req_unsigned,
                                       addr: req_addr, wdata: req_wdata};
                        req_ready <= 1'b0;
                        cnt       <= 4'(LATENCY - 1);
                        state     <= (LATENCY == 1) ? S_RESP : S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt <= 4'd1) begin
                        cnt   <= '0;
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err;
                    rsp_rdata <= (req_q.we | err) ? 32'h0 : ldata;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Byte-enabled write of the merged word; contents are never reset.
    genvar l;
    generate
        for (l = 0; l < NUM_LANES; l++) begin : g_wr
            always_ff @(posedge clk) begin
                if (!rst && commit && be[l])
                    mem[idx][l*LANE_W +: LANE_W] <= merged[l*LANE_W +: LANE_W];
            end
        end
    endgenerate

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed cases plus randomized traffic
// checked against a byte-level reference model of the word array.
module tb_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int NWORD = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    typedef struct {
        time         t;
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    exp_t      sbq[$];
    int        checks = 0;
    int        errors = 0;
    bit [31:0] mdl [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed view of the array, plain arithmetic.
    function automatic void model(input bit we, input bit [1:0] size, input bit uns,
                                  input bit [31:0] addr, input bit [31:0] wdata,
                                  output bit [31:0] rd, output bit er);
        int nb, off, idx;
        bit [31:0] w, v, mask;
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        idx = int'((addr / 4) % DEPTH);
        off = (int'(addr % 4) / nb) * nb;
        er  = 1'b0;
`ifdef MEM_ERR_EN
        er = ((addr % nb) != 0) || (addr >= DEPTH * 4);
`endif
        rd = '0;
        if (er) return;
        w = mdl[idx];
        if (we) begin
            for (int b = 0; b < nb; b++) w[8*(off+b) +: 8] = wdata[8*b +: 8];
            mdl[idx] = w;
        end else begin
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
            v = (w >> (8 * off)) & mask;
            if (!uns && nb < 4 && v[8*nb-1]) v = v | ~mask;
            rd = v;
        end
    endfunction

    // Issue one request; mode 0 = model expectation, 1 = fixed expectation,
    // 2 = no response expected (request will be aborted by reset).
    task automatic issue(input string name, input bit we, input bit [1:0] size, input bit uns,
                         input bit [31:0] addr, input bit [31:0] wdata,
                         input int mode, input bit [31:0] k_rd, input bit k_er);
        exp_t e;
        bit [31:0] rd;
        bit er;
        int guard = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout %s: got %b expected 1", name, req_ready);
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        if (mode != 2) begin
            model(we, size, uns, addr, wdata, rd, er);
            e.t     = $time + (LAT + 1) * 10;
            e.rdata = (mode == 1) ? k_rd : rd;
            e.err   = (mode == 1) ? k_er : er;
            e.name  = name;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Monitor: every rsp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checks++;
                if ($time != e.t) begin
                    errors++;
                    $display("FAIL %s latency: got rsp at %0t expected %0t", e.name, $time, e.t);
                end
                check({e.name, " rdata"}, rsp_rdata, e.rdata);
                check({e.name, " err"}, {31'b0, rsp_err}, {31'b0, e.err});
            end
        end
    end

    initial begin
        bit [31:0] a;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", {31'b0, req_ready}, 32'd1);
        check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset rsp_err",   {31'b0, rsp_err}, 32'd0);
        rst = 1'b0;

        // Give the modelled window defined contents.
        for (int w = 0; w < NWORD; w++)
            issue("init", 1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom, 0, 0, 0);

        issue("st_w_10",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1, 32'h0, 1'b0);
        issue("ld_w_10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
        issue("clr_10",   1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1, 32'h0, 1'b0);
        issue("st_b_11",  1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00A5, 1, 32'h0, 1'b0);
        issue("ld_bs_11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1, 32'hFFFF_FFA5, 1'b0);
        issue("ld_bu_11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1, 32'h0000_00A5, 1'b0);
        issue("ld_w_10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 32'h0000_A500, 1'b0);
        issue("st_w_half",1'b1, 2'b10, 1'b0, 32'h10, 32'h8001_1234, 1, 32'h0, 1'b0);
        issue("ld_hs_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1, 32'hFFFF_8001, 1'b0);
        issue("ld_hu_12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1, 32'h0000_8001, 1'b0);
        issue("ld_hs_10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1, 32'h0000_1234, 1'b0);

        // Store aborted by reset while BUSY must neither respond nor commit.
        issue("abort_st", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 2, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst req_ready", {31'b0, req_ready}, 32'd1);
        check("post_rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        rst = 1'b0;
        issue("ld_after_abort", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 32'h8001_1234, 1'b0);

`ifdef MEM_ERR_EN
        issue("ld_w_misal", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 1, 32'h0, 1'b1);
        issue("st_oor", 1'b1, 2'b10, 1'b0, DEPTH * 4, 32'hCAFE_F00D, 1, 32'h0, 1'b1);
`else
        issue("ld_w_misal", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 0, 0, 0);
        issue("st_oor", 1'b1, 2'b10, 1'b0, DEPTH * 4, 32'hCAFE_F00D, 0, 0, 0);
`endif
        issue("ld_w0", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, 0, 0);
        issue("ld_h_13", 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 0, 0, 0);
        issue("st_sz3", 1'b1, 2'b11, 1'b0, 32'h21, 32'h5A5A_1111, 0, 0, 0);
        issue("ld_sz3", 1'b0, 2'b11, 1'b1, 32'h20, 32'h0, 0, 0, 0);

        // Randomized traffic over the modelled window, some with high address bits.
        for (int n = 0; n < 300; n++) begin
            a = 32'($urandom_range(0, NWORD - 1) * 4) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) a = a | (32'($urandom_range(1, 7)) << 12);
            issue("rand", 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 0, 0, 0);
        end

        // Let the last response drain, bounded.
        for (int c = 0; c < 20 && sbq.size() != 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("drain pending", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
